// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle between the two requesters (C = CPU, D = DMA/debug), the arbiter and the shared bus slave.
// slave: the arbiter itself; master: the requesters and the bus slave that surround it.
interface mem_bus_arbiter_if;
    logic        c_req;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_byteen;
    logic        c_done;
    logic        c_err;
    logic [31:0] c_rdata;

    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteen;
    logic        d_done;
    logic        d_err;
    logic [31:0] d_rdata;

    logic        m_valid;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_byteen;
    logic        m_ready;
    logic [31:0] m_rdata;

    logic        owner;
    logic        busy;

    modport slave (
        input  c_req, c_addr, c_wdata, c_byteen,
        output c_done, c_err, c_rdata,
        input  d_req, d_addr, d_wdata, d_byteen,
        output d_done, d_err, d_rdata,
        output m_valid, m_addr, m_wdata, m_byteen,
        input  m_ready, m_rdata,
        output owner, busy
    );

    modport master (
        output c_req, c_addr, c_wdata, c_byteen,
        input  c_done, c_err, c_rdata,
        output d_req, d_addr, d_wdata, d_byteen,
        input  d_done, d_err, d_rdata,
        input  m_valid, m_addr, m_wdata, m_byteen,
        output m_ready, m_rdata,
        input  owner, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the shared data-memory bus: latches one request, drives the bus until
// the slave acknowledges or a timeout fires, then returns a one-cycle completion to the winner.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 15
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_arbiter_if.slave   bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t      r_state;
    logic [SW-1:0] r_starve_cnt;
    logic [WW-1:0] r_wait_cnt;
    logic        r_owner;
    logic        r_busy;
    logic        r_m_valid;
    logic [31:0] r_m_addr;
    logic [31:0] r_m_wdata;
    logic [3:0]  r_m_byteen;
    logic        r_c_done;
    logic        r_c_err;
    logic [31:0] r_c_rdata;
    logic        r_d_done;
    logic        r_d_err;
    logic [31:0] r_d_rdata;

    logic        w_any_req;
    logic        w_grant_d;
    logic        w_starved;
    logic [SW-1:0] w_starve_next;
    logic        w_timeout;
    logic        w_finish;
    logic [31:0] w_rsp_data;

    assign w_any_req = bus.c_req | bus.d_req;
    assign w_starved = (r_starve_cnt == SW'(STARVE_LIMIT));
    assign w_grant_d = bus.d_req & (~bus.c_req | w_starved);

    // Only C wins while D waits advance the counter; any other grant resets it.
    always_comb begin
        w_starve_next = '0;
        if (!w_grant_d && bus.d_req) begin
            w_starve_next = w_starved ? r_starve_cnt : r_starve_cnt + SW'(1);
        end
    end

    assign w_timeout  = (r_wait_cnt == WW'(TIMEOUT));
    assign w_finish   = bus.m_ready | w_timeout;
    assign w_rsp_data = bus.m_ready ? bus.m_rdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_wait_cnt   <= '0;
            r_owner      <= 1'b0;
            r_busy       <= 1'b0;
            r_m_valid    <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_m_byteen   <= '0;
            r_c_done     <= 1'b0;
            r_c_err      <= 1'b0;
            r_c_rdata    <= '0;
            r_d_done     <= 1'b0;
            r_d_err      <= 1'b0;
            r_d_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state      <= BUSY;
                        r_owner      <= w_grant_d;
                        r_starve_cnt <= w_starve_next;
                        r_m_addr     <= w_grant_d ? bus.d_addr   : bus.c_addr;
                        r_m_wdata    <= w_grant_d ? bus.d_wdata  : bus.c_wdata;
                        r_m_byteen   <= w_grant_d ? bus.d_byteen : bus.c_byteen;
                        r_m_valid    <= 1'b1;
                        r_busy       <= 1'b1;
                        r_wait_cnt   <= WW'(1);
                    end
                end
                BUSY: begin
                    // wait_cnt holds the index of the BUSY cycle being closed by this edge.
                    if (w_finish) begin
                        r_state    <= RESP;
                        r_m_valid  <= 1'b0;
                        r_wait_cnt <= '0;
                        if (r_owner) begin
                            r_d_done  <= 1'b1;
                            r_d_err   <= ~bus.m_ready;
                            r_d_rdata <= w_rsp_data;
                        end else begin
                            r_c_done  <= 1'b1;
                            r_c_err   <= ~bus.m_ready;
                            r_c_rdata <= w_rsp_data;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WW'(1);
                    end
                end
                RESP: begin
                    r_state   <= IDLE;
                    r_busy    <= 1'b0;
                    r_c_done  <= 1'b0;
                    r_c_err   <= 1'b0;
                    r_c_rdata <= '0;
                    r_d_done  <= 1'b0;
                    r_d_err   <= 1'b0;
                    r_d_rdata <= '0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.m_valid  = r_m_valid;
    assign bus.m_addr   = r_m_addr;
    assign bus.m_wdata  = r_m_wdata;
    assign bus.m_byteen = r_m_byteen;
    assign bus.c_done   = r_c_done;
    assign bus.c_err    = r_c_err;
    assign bus.c_rdata  = r_c_rdata;
    assign bus.d_done   = r_d_done;
    assign bus.d_err    = r_d_err;
    assign bus.d_rdata  = r_d_rdata;
    assign bus.owner    = r_owner;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a transaction-level model checked every cycle, plus
// hand-computed expectations for each scenario.
module tb_mem_bus_arbiter;

    localparam int SL = 4;
    localparam int TO = 15;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   cyc;

    mem_bus_arbiter_if bus();

    mem_bus_arbiter #(
        .STARVE_LIMIT(SL),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one transaction at a time, described by its age in edges since the grant.
    bit          md_in_txn;
    int          md_age;
    int          md_done_age;
    bit          md_who;
    logic [31:0] md_addr;
    logic [31:0] md_wdata;
    logic [3:0]  md_be;
    bit          md_err;
    logic [31:0] md_data;
    int          md_starve;

    task automatic model_clear();
        md_in_txn = 0; md_age = 0; md_done_age = -1; md_who = 0;
        md_addr = '0; md_wdata = '0; md_be = '0; md_err = 0; md_data = '0; md_starve = 0;
    endtask

    task automatic model_step();
        if (!md_in_txn) begin
            if (bus.c_req || bus.d_req) begin
                md_who = bus.d_req && (!bus.c_req || md_starve == SL);
                if (md_who) md_starve = 0;
                else if (bus.d_req) md_starve = (md_starve < SL) ? md_starve + 1 : SL;
                else md_starve = 0;
                md_addr  = md_who ? bus.d_addr   : bus.c_addr;
                md_wdata = md_who ? bus.d_wdata  : bus.c_wdata;
                md_be    = md_who ? bus.d_byteen : bus.c_byteen;
                md_in_txn = 1; md_age = 0; md_done_age = -1;
            end
        end else begin
            md_age++;
            if (md_done_age < 0) begin
                if (bus.m_ready) begin
                    md_err = 0; md_data = bus.m_rdata; md_done_age = md_age;
                end else if (md_age == TO) begin
                    md_err = 1; md_data = '0; md_done_age = md_age;
                end
            end else begin
                md_in_txn = 0;
            end
        end
    endtask

    task automatic model_loop();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_clear();
            else begin
                cyc++;
                model_step();
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        bit mv, dn, cd, dd;
        forever begin
            @(negedge clk);
            mv = md_in_txn && (md_done_age < 0);
            dn = md_in_txn && (md_done_age >= 0);
            cd = dn && !md_who;
            dd = dn && md_who;
            chk("m_valid",  {31'd0, bus.m_valid}, {31'd0, mv});
            chk("busy",     {31'd0, bus.busy},    {31'd0, md_in_txn});
            chk("owner",    {31'd0, bus.owner},   {31'd0, md_who});
            chk("m_addr",   bus.m_addr,  md_addr);
            chk("m_wdata",  bus.m_wdata, md_wdata);
            chk("m_byteen", {28'd0, bus.m_byteen}, {28'd0, md_be});
            chk("c_done",   {31'd0, bus.c_done}, {31'd0, cd});
            chk("c_err",    {31'd0, bus.c_err},  {31'd0, cd && md_err});
            chk("c_rdata",  bus.c_rdata, cd ? md_data : 32'h0);
            chk("d_done",   {31'd0, bus.d_done}, {31'd0, dd});
            chk("d_err",    {31'd0, bus.d_err},  {31'd0, dd && md_err});
            chk("d_rdata",  bus.d_rdata, dd ? md_data : 32'h0);
        end
    endtask

    // which: 0 c_done, 1 d_done, 2 m_valid, 3 idle
    task automatic wait_sig(input int which, input string nm);
        int n;
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < 60) begin
            @(negedge clk);
            n++;
            case (which)
                0: hit = bus.c_done;
                1: hit = bus.d_done;
                2: hit = bus.m_valid;
                default: hit = !bus.busy;
            endcase
        end
        chk(nm, {31'd0, hit}, 32'd1);
    endtask

    initial begin
        int t0;
        int n_mv;
        int g;
        bit prev;
        bit got;
        bit owners[10];
        bit exp_seq[10];

        tests = 0; fails = 0; cyc = 0;
        model_clear();
        bus.c_req = 0; bus.c_addr = '0; bus.c_wdata = '0; bus.c_byteen = '0;
        bus.d_req = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_byteen = '0;
        bus.m_ready = 0; bus.m_rdata = '0;
        reset = 1'b1;
        fork
            model_loop();
            compare_loop();
            begin
                #100000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none
        #1 reset = 1'b0;
        #1;
        chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("rst_busy",    {31'd0, bus.busy},    32'd0);
        chk("rst_c_done",  {31'd0, bus.c_done},  32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // CPU read
        bus.c_req = 1; bus.c_addr = 32'h0000_1000; bus.c_wdata = '0; bus.c_byteen = 4'b0000;
        bus.m_ready = 1; bus.m_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("s1_m_valid",  {31'd0, bus.m_valid}, 32'd1);
        chk("s1_m_addr",   bus.m_addr, 32'h0000_1000);
        chk("s1_m_byteen", {28'd0, bus.m_byteen}, 32'd0);
        @(negedge clk);
        chk("s1_c_done",  {31'd0, bus.c_done}, 32'd1);
        chk("s1_c_rdata", bus.c_rdata, 32'hDEAD_BEEF);
        chk("s1_c_err",   {31'd0, bus.c_err}, 32'd0);
        chk("s1_d_done",  {31'd0, bus.d_done}, 32'd0);
        chk("s1_mv_low",  {31'd0, bus.m_valid}, 32'd0);
        bus.c_req = 0;
        @(negedge clk);
        chk("s1_idle", {31'd0, bus.busy}, 32'd0);

        // Simultaneous requests
        bus.c_req = 1; bus.c_addr = 32'h2000; bus.c_wdata = 32'h1111_1111; bus.c_byteen = 4'hF;
        bus.d_req = 1; bus.d_addr = 32'h2004; bus.d_wdata = 32'h2222_2222; bus.d_byteen = 4'hF;
        bus.m_rdata = 32'h0;
        wait_sig(0, "s2_c_done_seen");
        chk("s2_c_owner", {31'd0, bus.owner}, 32'd0);
        t0 = cyc;
        bus.c_req = 0;
        wait_sig(2, "s2_d_mvalid_seen");
        chk("s2_d_gap",   32'(cyc - t0), 32'd2);
        chk("s2_d_owner", {31'd0, bus.owner}, 32'd1);
        chk("s2_d_addr",  bus.m_addr, 32'h2004);
        wait_sig(1, "s2_d_done_seen");
        bus.d_req = 0;
        wait_sig(3, "s2_idle");

        // Starvation: both requests held
        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        bus.c_req = 1; bus.c_addr = 32'h100; bus.c_byteen = 4'h0;
        bus.d_req = 1; bus.d_addr = 32'h200; bus.d_byteen = 4'h0;
        bus.m_ready = 1; bus.m_rdata = 32'h5555_AAAA;
        g = 0;
        prev = bus.m_valid;
        for (int n = 0; n < 120 && g < 10; n++) begin
            @(negedge clk);
            if (bus.m_valid && !prev) begin
                owners[g] = bus.owner;
                g++;
            end
            prev = bus.m_valid;
        end
        bus.c_req = 0; bus.d_req = 0;
        chk("s3_grant_count", 32'(g), 32'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("s3_grant%0d", i), {31'd0, owners[i]}, {31'd0, exp_seq[i]});
        end
        wait_sig(3, "s3_idle");

        // Timeout on a D write, C queued behind it
        bus.m_ready = 0;
        bus.d_req = 1; bus.d_addr = 32'h3000; bus.d_wdata = 32'hA5A5_A5A5; bus.d_byteen = 4'b0011;
        n_mv = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.m_valid) n_mv++;
            if (i == 0) begin
                bus.c_req = 1; bus.c_addr = 32'h4000; bus.c_byteen = 4'b0000;
            end
            if (bus.d_done) got = 1;
        end
        chk("s4_d_done_seen", {31'd0, got}, 32'd1);
        chk("s4_mvalid_cycles", 32'(n_mv), 32'd15);
        chk("s4_d_err",   {31'd0, bus.d_err}, 32'd1);
        chk("s4_d_rdata", bus.d_rdata, 32'h0);
        chk("s4_c_done",  {31'd0, bus.c_done}, 32'd0);
        bus.d_req = 0;
        bus.m_ready = 1; bus.m_rdata = 32'hCAFE_F00D;
        wait_sig(2, "s4_c_mvalid_seen");
        chk("s4_c_owner", {31'd0, bus.owner}, 32'd0);
        chk("s4_c_addr",  bus.m_addr, 32'h4000);
        wait_sig(0, "s4_c_done_seen");
        chk("s4_c_err",   {31'd0, bus.c_err}, 32'd0);
        chk("s4_c_rdata", bus.c_rdata, 32'hCAFE_F00D);
        bus.c_req = 0;
        wait_sig(3, "s4_idle");

        // m_ready arrives in the last allowed BUSY cycle
        bus.m_ready = 0; bus.m_rdata = 32'h1234_5678;
        bus.c_req = 1; bus.c_addr = 32'h5000; bus.c_byteen = 4'b0000;
        n_mv = 0;
        for (int i = 0; i < 40 && n_mv < 15; i++) begin
            @(negedge clk);
            if (bus.m_valid) n_mv++;
        end
        bus.m_ready = 1;
        chk("s5_mvalid_cycles", 32'(n_mv), 32'd15);
        @(negedge clk);
        chk("s5_c_done",  {31'd0, bus.c_done}, 32'd1);
        chk("s5_c_err",   {31'd0, bus.c_err}, 32'd0);
        chk("s5_c_rdata", bus.c_rdata, 32'h1234_5678);
        bus.c_req = 0;
        wait_sig(3, "s5_idle");

        // Asynchronous reset in the middle of a D transaction
        bus.m_ready = 0;
        bus.d_req = 1; bus.d_addr = 32'h6000; bus.d_byteen = 4'hF;
        repeat (3) @(negedge clk);
        chk("s6_pre_mvalid", {31'd0, bus.m_valid}, 32'd1);
        chk("s6_pre_owner",  {31'd0, bus.owner}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("s6_rst_mvalid", {31'd0, bus.m_valid}, 32'd0);
        chk("s6_rst_busy",   {31'd0, bus.busy}, 32'd0);
        chk("s6_rst_owner",  {31'd0, bus.owner}, 32'd0);
        bus.d_req = 0;
        bus.c_req = 1; bus.c_addr = 32'h7000; bus.c_byteen = 4'b0000;
        bus.m_ready = 1; bus.m_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        chk("s6_no_d_done", {31'd0, bus.d_done}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("s6_post_mvalid", {31'd0, bus.m_valid}, 32'd1);
        chk("s6_post_addr",   bus.m_addr, 32'h7000);
        chk("s6_post_owner",  {31'd0, bus.owner}, 32'd0);
        @(negedge clk);
        chk("s6_post_c_done", {31'd0, bus.c_done}, 32'd1);
        bus.c_req = 0;
        wait_sig(3, "s6_idle");
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
